// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronises rx, frames start/data/stop bits on baud ticks
// and presents each byte through a valid/ready slot with frame-error and overrun pulses.
module uart_rx_ctrl #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 clk_baud,
    output logic                 baud_enable,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_error,
    output logic                 overrun
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 baud_enable_q, baud_enable_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 frame_error_q, frame_error_d;
    logic                 overrun_q, overrun_d;
    logic                 slot_free;

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        data_out_d    = data_out_q;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;
        // A consumer taking the byte this cycle frees the slot for a same-cycle load.
        slot_free     = !data_valid_q || data_ready;
        data_valid_d  = data_valid_q && !data_ready;

        case (state_q)
            StIdle: begin
                if (!rx_s_q) state_d = StStart;
            end
            StStart: begin
                if (clk_baud) begin
                    if (!rx_s_q) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (clk_baud) begin
                    shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) state_d = StStop;
                end
            end
            StStop: begin
                if (clk_baud) begin
                    state_d = StIdle;
                    if (!rx_s_q) begin
                        frame_error_d = 1'b1;
                    end else if (slot_free) begin
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Dropping to idle forces one low cycle so the baud generator reloads its phase.
        baud_enable_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            baud_enable_q <= 1'b0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_meta_q     <= rx;
            rx_s_q        <= rx_meta_q;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            baud_enable_q <= baud_enable_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    assign baud_enable = baud_enable_q;
    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: paired with a BAUDRATE=16 Rx baud generator, directed scenarios
// plus randomized frames checked against a transaction-level slot model.
module tb_uart_rx_ctrl;

    localparam int DB    = 8;
    localparam int BIT_T = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx = 1'b1;
    logic          data_ready = 1'b0;
    logic          clk_baud;
    logic          baud_enable, data_valid, frame_error, overrun;
    logic [DB-1:0] data_out;

    int checks = 0;
    int errors = 0;

    logic [3:0]    bg_cnt = 4'd7;
    logic          abort = 1'b0;
    int            fe_cnt = 0, ov_cnt = 0, ov_tick_ok = 0, vld_cnt = 0;
    logic          tick_prev = 1'b0;
    logic [DB-1:0] got_q[$];

    uart_rx_ctrl #(.DATA_BITS(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .clk_baud   (clk_baud),
        .baud_enable(baud_enable),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_error(frame_error),
        .overrun    (overrun)
    );

    always #10 clk = ~clk;

    // Rx baud generator, BAUDRATE=16: preload 7 while disabled, tick when the count hits 15.
    always @(posedge clk) begin
        if (!reset || !baud_enable) bg_cnt <= 4'd7;
        else bg_cnt <= bg_cnt + 4'd1;
    end
    assign clk_baud = baud_enable && (bg_cnt == 4'd15);

    // Per-cycle observer, sampled mid-cycle once inputs have settled.
    always begin
        @(negedge clk);
        #1;
        if (frame_error === 1'b1) fe_cnt++;
        if (overrun === 1'b1) begin
            ov_cnt++;
            if (tick_prev) ov_tick_ok++;
        end
        if (data_valid === 1'b1) vld_cnt++;
        if (reset && data_valid === 1'b1 && data_ready) got_q.push_back(data_out);
        tick_prev = clk_baud;
    end

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation did not complete within 60000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        data_ready = 1'b0;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // 8N1 frame, LSB first; stop bit level selectable; stops early when abort is raised.
    task automatic send_frame(input logic [DB-1:0] b, input logic stop);
        for (int k = 0; k < (DB + 2) * BIT_T; k++) begin
            int sym;
            if (abort) break;
            sym = k / BIT_T;
            if (sym == 0) rx = 1'b0;
            else if (sym <= DB) rx = b[sym-1];
            else rx = stop;
            @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic wait_ticks(input int n, input string tag);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (clk_baud === 1'b1) seen++;
        end
        checks++;
        if (seen < n) begin
            errors++;
            $display("FAIL %s_tick_timeout: got %0d ticks, expected %0d", tag, seen, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({baud_enable, data_valid, frame_error, overrun, data_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got be=%b vld=%b fe=%b ov=%b data=%h, expected all 0",
                     baud_enable, data_valid, frame_error, overrun, data_out);
        end
        reset = 1'b1;
        idle(3);
    endtask

    task automatic test_single_frame();
        int fe0, ov0;
        do_reset();
        got_q.delete();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_frame(8'hA5, 1'b1);
        idle(20);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'hA5) begin
            errors++;
            $display("FAIL single_load: got vld=%b data=%h, expected vld=1 data=a5",
                     data_valid, data_out);
        end
        idle(10);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'hA5) begin
            errors++;
            $display("FAIL single_hold: got vld=%b data=%h, expected vld=1 data=a5",
                     data_valid, data_out);
        end
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_consume: got vld=%b, expected 0", data_valid);
        end
        @(negedge clk);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'hA5 || fe_cnt != fe0 || ov_cnt != ov0) begin
            errors++;
            $display("FAIL single_handshake: got %0d bytes fe=%0d ov=%0d, expected 1 byte a5 no flags",
                     got_q.size(), fe_cnt - fe0, ov_cnt - ov0);
        end
    endtask

    task automatic test_false_start();
        int fe0, ov0, v0, be_hi;
        do_reset();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        v0 = vld_cnt;
        be_hi = 0;
        rx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 3) rx = 1'b1;
            @(negedge clk);
            if (baud_enable === 1'b1) be_hi++;
        end
        checks++;
        if (be_hi != 9) begin
            errors++;
            $display("FAIL false_start_enable_cycles: got %0d, expected 9", be_hi);
        end
        checks++;
        if (vld_cnt != v0 || fe_cnt != fe0 || ov_cnt != ov0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL false_start_quiet: got vld=%0d fe=%0d ov=%0d data=%h, expected none",
                     vld_cnt - v0, fe_cnt - fe0, ov_cnt - ov0, data_out);
        end
    endtask

    task automatic test_framing();
        int fe0, ov0, v0;
        do_reset();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        v0 = vld_cnt;
        send_frame(8'h3C, 1'b0);
        idle(30);
        checks++;
        if (fe_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL framing_pulse: got %0d error cycles, expected 1", fe_cnt - fe0);
        end
        checks++;
        if (vld_cnt != v0 || data_out !== 8'h00 || ov_cnt != ov0) begin
            errors++;
            $display("FAIL framing_discard: got vld=%0d data=%h ov=%0d, expected 0 00 0",
                     vld_cnt - v0, data_out, ov_cnt - ov0);
        end
    endtask

    task automatic test_overrun();
        int fe0, ov0, ot0, bad;
        do_reset();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        ot0 = ov_tick_ok;
        bad = 0;
        send_frame(8'h11, 1'b1);
        idle(20);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h11) begin
            errors++;
            $display("FAIL overrun_first: got vld=%b data=%h, expected 1 11", data_valid, data_out);
        end
        fork
            send_frame(8'h22, 1'b1);
            for (int i = 0; i < 175; i++) begin
                @(negedge clk);
                if (!(data_valid === 1'b1 && data_out === 8'h11)) bad++;
            end
        join
        idle(10);
        checks++;
        if (bad != 0 || data_out !== 8'h11 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_hold: got %0d disturbed cycles data=%h, expected 0 and 11",
                     bad, data_out);
        end
        checks++;
        if (ov_cnt - ov0 != 1 || ov_tick_ok - ot0 != 1 || fe_cnt != fe0) begin
            errors++;
            $display("FAIL overrun_pulse: got ov=%0d after_tick=%0d fe=%0d, expected 1 1 0",
                     ov_cnt - ov0, ov_tick_ok - ot0, fe_cnt - fe0);
        end
    endtask

    task automatic test_back_to_back();
        int fe0, ov0, v0;
        do_reset();
        got_q.delete();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        v0 = vld_cnt;
        data_ready = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        data_ready = 1'b0;
        checks++;
        if (got_q.size() != 2 || got_q[0] !== 8'h00 || got_q[1] !== 8'hFF ||
            vld_cnt - v0 != 2 || fe_cnt != fe0 || ov_cnt != ov0) begin
            errors++;
            $display("FAIL b2b_stream: got %0d bytes, %0d valid cycles, fe=%0d ov=%0d, expected 00,ff in 2 cycles no flags",
                     got_q.size(), vld_cnt - v0, fe_cnt - fe0, ov_cnt - ov0);
        end

        do_reset();
        got_q.delete();
        ov0 = ov_cnt;
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                wait_ticks(20, "b2b");
                data_ready = 1'b1;
                @(negedge clk);
                data_ready = 1'b0;
                checks++;
                if (data_valid !== 1'b1 || data_out !== 8'hFF) begin
                    errors++;
                    $display("FAIL b2b_replace: got vld=%b data=%h, expected 1 ff",
                             data_valid, data_out);
                end
            end
        join
        idle(20);
        checks++;
        if (ov_cnt != ov0 || got_q.size() != 1 || got_q[0] !== 8'h00 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_overrun: got ov=%0d bytes=%0d vld=%b, expected 0 1 1",
                     ov_cnt - ov0, got_q.size(), data_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        int fe0, ov0;
        logic [DB-1:0] b0;
        do_reset();
        b0 = 8'($urandom_range(1, 255));
        send_frame(b0, 1'b1);
        idle(20);
        checks++;
        if (data_valid !== 1'b1 || data_out !== b0) begin
            errors++;
            $display("FAIL rst_mid_preload: got vld=%b data=%h, expected 1 %h",
                     data_valid, data_out, b0);
        end
        fork
            send_frame(8'h5A, 1'b1);
            begin
                wait_ticks(4, "rst_mid");
                repeat (8) @(negedge clk);
                abort = 1'b1;
                reset = 1'b0;
                @(negedge clk);
                checks++;
                if ({baud_enable, data_valid, frame_error, overrun, data_out} !== '0) begin
                    errors++;
                    $display("FAIL rst_mid_outputs: got be=%b vld=%b fe=%b ov=%b data=%h, expected all 0",
                             baud_enable, data_valid, frame_error, overrun, data_out);
                end
                repeat (2) @(negedge clk);
                reset = 1'b1;
            end
        join
        abort = 1'b0;
        rx = 1'b1;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        idle(40);
        checks++;
        if (baud_enable !== 1'b0 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_quiet: got be=%b vld=%b, expected 0 0", baud_enable, data_valid);
        end
        send_frame(8'h5A, 1'b1);
        idle(20);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h5A || fe_cnt != fe0 || ov_cnt != ov0) begin
            errors++;
            $display("FAIL rst_mid_recover: got vld=%b data=%h fe=%0d ov=%0d, expected 1 5a 0 0",
                     data_valid, data_out, fe_cnt - fe0, ov_cnt - ov0);
        end
    endtask

    // Model: a single output slot (full flag, last loaded byte) updated per frame.
    task automatic test_random(input int n);
        logic          m_full;
        logic [DB-1:0] m_last, b;
        logic          stop, pre_consume, stop_consume;
        logic [DB-1:0] exp_q[$];
        int            fe0, ov0, exp_fe, exp_ov;
        do_reset();
        got_q.delete();
        m_full = 1'b0;
        m_last = '0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        exp_fe = 0;
        exp_ov = 0;
        for (int it = 0; it < n; it++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            pre_consume = 1'($urandom_range(0, 1));
            stop_consume = ($urandom_range(0, 2) == 0);
            if (pre_consume) begin
                data_ready = 1'b1;
                @(negedge clk);
                data_ready = 1'b0;
                if (m_full) begin
                    exp_q.push_back(m_last);
                    m_full = 1'b0;
                end
            end
            fork
                send_frame(b, stop);
                begin
                    if (stop_consume) begin
                        wait_ticks(10, "rand");
                        data_ready = 1'b1;
                        @(negedge clk);
                        data_ready = 1'b0;
                    end
                end
            join
            if (stop_consume && m_full) begin
                exp_q.push_back(m_last);
                m_full = 1'b0;
            end
            if (!stop) exp_fe++;
            else if (m_full) exp_ov++;
            else begin
                m_last = b;
                m_full = 1'b1;
            end
            idle($urandom_range(20, 40));
            checks++;
            if (data_valid !== m_full || data_out !== m_last) begin
                errors++;
                $display("FAIL rand_slot[%0d]: got vld=%b data=%h, expected vld=%b data=%h",
                         it, data_valid, data_out, m_full, m_last);
            end
            checks++;
            if (fe_cnt - fe0 != exp_fe || ov_cnt - ov0 != exp_ov) begin
                errors++;
                $display("FAIL rand_flags[%0d]: got fe=%0d ov=%0d, expected fe=%0d ov=%0d",
                         it, fe_cnt - fe0, ov_cnt - ov0, exp_fe, exp_ov);
            end
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand_consumed_count[%0d]: got %0d, expected %0d",
                         it, got_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[k]) begin
                    checks++;
                    if (got_q[k] !== exp_q[k]) begin
                        errors++;
                        $display("FAIL rand_consumed_byte[%0d]: got %h, expected %h",
                                 it, got_q[k], exp_q[k]);
                    end
                end
            end
            got_q.delete();
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_false_start();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        test_random(16);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
